// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one Kogge-Stone adder among N_REQ requesters.
// Results land in a single registered response slot with 1-cycle latency.
module ks_add #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int LV = $clog2(WIDTH);

    logic [WIDTH-1:0] g, p, gn, pn;

    // Each level doubles the span of the group generate/propagate terms.
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gn = g;
        pn = p;
        for (int l = 0; l < LV; l++) begin
            gn = g;
            pn = p;
            for (int i = (1 << l); i < WIDTH; i++) begin
                gn[i] = g[i] | (p[i] & g[i-(1<<l)]);
                pn[i] = p[i] & p[i-(1<<l)];
            end
            g = gn;
            p = pn;
        end
        sum  = (a ^ b) ^ {g[WIDTH-2:0], 1'b0};
        cout = g[WIDTH-1];
    end
endmodule

module adder_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic                   rsp_cout,
    output logic [ID_W-1:0]        rsp_id,
    output logic [15:0]            ops_done
);
    localparam int PW = ID_W + 1;

    logic [ID_W-1:0]  rr_ptr, win;
    logic [PW-1:0]    idx;
    logic             any_valid, accept, xfer;
    logic [WIDTH-1:0] op_a, op_b, add_sum;
    logic             add_cout;

    // Scan from rr_ptr upward, wrapping at N_REQ; first valid index wins.
    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, rr_ptr} + PW'(k);
            if (idx >= PW'(N_REQ))
                idx = idx - PW'(N_REQ);
            if (!any_valid && req_valid[idx[ID_W-1:0]]) begin
                any_valid = 1'b1;
                win       = idx[ID_W-1:0];
            end
        end
    end

    assign accept    = ~rsp_valid | rsp_ready;
    assign xfer      = rst_n & accept & any_valid;
    assign req_ready = xfer ? (N_REQ'(1) << win) : '0;

    assign op_a = req_a[win*WIDTH +: WIDTH];
    assign op_b = req_b[win*WIDTH +: WIDTH];

    ks_add #(.WIDTH(WIDTH)) u_add (
        .a    (op_a),
        .b    (op_b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
            rr_ptr    <= '0;
            ops_done  <= '0;
        end else if (xfer) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= add_sum;
            rsp_cout  <= add_cout;
            rsp_id    <= win;
            rr_ptr    <= (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
            ops_done  <= ops_done + 16'd1;
        end else if (rsp_ready) begin
            // Drained with nothing to refill: payload keeps its last value.
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed table plus hand sequences for the shared-adder arbiter.
module tb_adder_share_arbiter;
    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready, rsp_cout;
    logic [W-1:0]   rsp_sum;
    logic [1:0]     rsp_id;
    logic [15:0]    ops_done;

    int tests = 0;
    int fails = 0;

    adder_share_arbiter #(.N_REQ(N), .ID_W(2), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    vec_t        tbl[8];
    int          exp_ops;
    int          ptr;
    logic [15:0] ea[N];
    logic [15:0] eb[N];
    logic [16:0] gold;

    initial begin
        tbl[0] = '{0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        tbl[1] = '{1, 16'h1234, 16'h4321, 16'h5555, 1'b0};
        tbl[2] = '{2, 16'h8000, 16'h8000, 16'h0000, 1'b1};
        tbl[3] = '{3, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
        tbl[4] = '{1, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        tbl[5] = '{2, 16'h00FF, 16'h0001, 16'h0100, 1'b0};
        tbl[6] = '{0, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0};
        tbl[7] = '{3, 16'h7FFF, 16'h0001, 16'h8000, 1'b0};

        rst_n = 1'b0; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        tick(); tick();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_sum",   32'(rsp_sum),   32'h0);
        chk("rst_id",    32'(rsp_id),    32'h0);
        chk("rst_ops",   32'(ops_done),  32'h0);

        // Single op with carry-out.
        rst_n = 1'b1; req_valid = 4'b0001; set_op(0, 16'hFFFF, 16'h0001);
        #1 chk("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("single_valid", 32'(rsp_valid), 32'h1);
        chk("single_res", {13'h0, rsp_id, rsp_cout, rsp_sum}, {13'h0, 2'd0, 1'b1, 16'h0000});
        chk("single_ops", 32'(ops_done), 32'd1);
        tick();
        chk("single_drain", 32'(rsp_valid), 32'h0);
        chk("single_hold", 32'(rsp_sum), 32'h0);
        exp_ops = 1;

        for (int v = 0; v < 8; v++) begin
            req_valid = 4'(1 << tbl[v].id);
            set_op(tbl[v].id, tbl[v].a, tbl[v].b);
            #1 chk("tbl_ready", 32'(req_ready), 32'(1 << tbl[v].id));
            tick();
            req_valid = '0;
            exp_ops++;
            chk("tbl_valid", 32'(rsp_valid), 32'h1);
            chk("tbl_sum",  32'(rsp_sum),  32'(tbl[v].sum));
            chk("tbl_cout", 32'(rsp_cout), 32'(tbl[v].cout));
            chk("tbl_id",   32'(rsp_id),   32'(tbl[v].id));
            chk("tbl_ops",  32'(ops_done), 32'(exp_ops));
        end

        // Full load: pointer is 0 after the last table grant to id 3.
        for (int i = 0; i < N; i++) set_op(i, 16'(32'h1000 * i + 1), 16'h0100);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_ops++;
            chk("full_id",  32'(rsp_id),  32'(k % 4));
            chk("full_res", {15'h0, rsp_cout, rsp_sum}, {15'h0, 1'b0, 16'(32'h1000 * (k % 4) + 32'h101)});
            chk("full_valid", 32'(rsp_valid), 32'h1);
        end

        // Backpressure holding the id 3 result.
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_ready", 32'(req_ready), 32'h0);
            tick();
            chk("bp_hold", {12'h0, rsp_valid, rsp_id, rsp_cout, rsp_sum}, {12'h0, 1'b1, 2'd3, 1'b0, 16'h3101});
            chk("bp_ops", 32'(ops_done), 32'(exp_ops));
        end
        rsp_ready = 1'b1;
        #1 chk("bp_release", 32'(req_ready), 32'h1);
        tick();
        exp_ops++;
        chk("bp_reload", {14'h0, rsp_id, rsp_sum}, {14'h0, 2'd0, 16'h0101});
        chk("bp_ops2", 32'(ops_done), 32'(exp_ops));

        // Pointer order: grant id 2, then 1010 must go 3 before 1.
        req_valid = 4'b0100; set_op(2, 16'h8000, 16'h8000);
        tick();
        chk("ptr_id2", {15'h0, rsp_id, rsp_cout, rsp_sum[12:0]}, {15'h0, 2'd2, 1'b1, 13'h0});
        chk("ptr_sum2", 32'(rsp_sum), 32'h0);
        req_valid = 4'b1010; set_op(3, 16'h8000, 16'h8000); set_op(1, 16'h0001, 16'h0002);
        #1 chk("ptr_ready3", 32'(req_ready), 32'h8);
        tick();
        chk("ptr_res3", {13'h0, rsp_id, rsp_cout, rsp_sum}, {13'h0, 2'd3, 1'b1, 16'h0000});
        req_valid = 4'b0010;
        #1 chk("ptr_ready1", 32'(req_ready), 32'h2);
        tick();
        chk("ptr_res1", {13'h0, rsp_id, rsp_cout, rsp_sum}, {13'h0, 2'd1, 1'b0, 16'h0003});

        // Reset while a response is pending and stalled.
        rsp_ready = 1'b0; req_valid = '1; rst_n = 1'b0;
        #1 chk("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        chk("mid_rst_state", {12'h0, rsp_valid, rsp_id, rsp_cout, rsp_sum}, 32'h0);
        chk("mid_rst_ops", 32'(ops_done), 32'h0);
        rst_n = 1'b1; rsp_ready = 1'b1; req_valid = 4'b1010;
        #1 chk("post_rst_ready", 32'(req_ready), 32'h2);
        tick();
        chk("post_rst_id", 32'(rsp_id), 32'd1);
        chk("post_rst_ops", 32'(ops_done), 32'd1);

        // Wrap the counter with random operands against a golden sum.
        for (int i = 0; i < N; i++) begin
            ea[i] = 16'($urandom); eb[i] = 16'($urandom);
            set_op(i, ea[i], eb[i]);
        end
        req_valid = '1;
        ptr = 2;
        for (int k = 0; k < 65535; k++) begin
            tick();
            gold = {1'b0, ea[ptr]} + {1'b0, eb[ptr]};
            chk("rand_res", {13'h0, rsp_id, gold[16], gold[15:0]}, {13'h0, rsp_id == 2'(ptr) ? rsp_id : 2'(ptr), rsp_cout, rsp_sum});
            ea[ptr] = 16'($urandom); eb[ptr] = 16'($urandom);
            set_op(ptr, ea[ptr], eb[ptr]);
            ptr = (ptr + 1) % N;
        end
        chk("wrap_ops", 32'(ops_done), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
